// File: rtl/clkdiv_pkg.sv
// -----------------------------------------------------------------------------
// clkdiv_pkg
//
// Shared definitions for the clock-divide buffer enable controller:
//   - state_e      : controller FSM states
//   - cnt_width()  : width of the single shared down-counter
//   - range limits : legal DIVIDE / NUM_REQ / CLR_HOLD / SETTLE values
// -----------------------------------------------------------------------------
package clkdiv_pkg;

    typedef enum logic [2:0] {
        OFF,
        RELEASE,
        ENABLE,
        RUN,
        DRAIN,
        CLEAR
    } state_e;

    localparam int DIVIDE_MIN     = 1;
    localparam int DIVIDE_MAX     = 8;
    localparam int NUM_REQ_MIN    = 1;
    localparam int NUM_REQ_MAX    = 8;
    localparam int CLR_HOLD_MIN   = 2;
    localparam int SETTLE_MIN     = 1;

    // Cycles buf_clr is held low before buf_ce rises on a restart.
    localparam int RELEASE_CYCLES = 2;

    // The one counter must hold the largest value any state loads into it.
    function automatic int cnt_width(input int settle, input int divide,
                                     input int clr_hold);
        int max_load;
        max_load = settle;
        if (2 * divide > max_load)      max_load = 2 * divide;
        if (clr_hold > max_load)        max_load = clr_hold;
        if (RELEASE_CYCLES > max_load)  max_load = RELEASE_CYCLES;
        return $clog2(max_load + 1);
    endfunction

endpackage

// File: rtl/clkdiv_enable_ctrl.sv
// -----------------------------------------------------------------------------
// clkdiv_enable_ctrl
//
// Sequences a clock-divide buffer (clear / enable) so that requesters only
// ever see a clean, settled divided clock:
//   OFF -> RELEASE -> ENABLE (settle) -> RUN -> DRAIN -> CLEAR -> OFF
//
// Ports
//   clk      in   controller clock (also the buffer input clock)
//   rst_n    in   asynchronous active-low reset
//   req      in   [NUM_REQ] level requests for the divided clock
//   gnt      out  [NUM_REQ] grants; divided clock valid while high
//   buf_ce   out  buffer clock-enable
//   buf_clr  out  buffer clear
//   busy     out  high whenever the controller is not in OFF
//   phase_stb out (only with CLKDIV_ENABLE_CTRL_PHASE_EN) one-cycle strobe
//                 in RUN on each rising edge of the divided clock
//
// Optional feature macro: CLKDIV_ENABLE_CTRL_PHASE_EN
// All outputs are registered; nothing flows combinationally from req.
// -----------------------------------------------------------------------------
module clkdiv_enable_ctrl
    import clkdiv_pkg::*;
#(
    parameter int DIVIDE   = 4,
    parameter int NUM_REQ  = 2,
    parameter int CLR_HOLD = 4,
    parameter int SETTLE   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               buf_ce,
    output logic               buf_clr,
    output logic               busy
`ifdef CLKDIV_ENABLE_CTRL_PHASE_EN
    ,
    output logic               phase_stb
`endif
);

    // Parameter legality, caught at elaboration.
    if (DIVIDE < DIVIDE_MIN || DIVIDE > DIVIDE_MAX) begin : g_bad_divide
        $error("clkdiv_enable_ctrl: DIVIDE out of range");
    end
    if (NUM_REQ < NUM_REQ_MIN || NUM_REQ > NUM_REQ_MAX) begin : g_bad_num_req
        $error("clkdiv_enable_ctrl: NUM_REQ out of range");
    end
    if (CLR_HOLD < CLR_HOLD_MIN) begin : g_bad_clr_hold
        $error("clkdiv_enable_ctrl: CLR_HOLD too small");
    end
    if (SETTLE < SETTLE_MIN) begin : g_bad_settle
        $error("clkdiv_enable_ctrl: SETTLE too small");
    end

    localparam int CNT_W = cnt_width(SETTLE, DIVIDE, CLR_HOLD);

    localparam logic [CNT_W-1:0] CNT_RELEASE  = CNT_W'(RELEASE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_SETTLE   = CNT_W'(SETTLE);
    localparam logic [CNT_W-1:0] CNT_DRAIN    = CNT_W'(2 * DIVIDE);
    localparam logic [CNT_W-1:0] CNT_CLR_HOLD = CNT_W'(CLR_HOLD);

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic             cnt_done;
    logic             req_any;

    // A state loaded with N occupies exactly N cycles: it leaves on the edge
    // where the counter reads 1.
    assign cnt_done = (cnt <= CNT_W'(1));
    assign req_any  = |req;

    // Outputs are assigned together with the transition that produces them,
    // so every output is a flop aligned with the state it belongs to.
    // NOTE: sequential state uses non-blocking (<=) so all flops update from
    // the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Reset reloads the clear-hold so the first restart after reset
            // still keeps the buffer cleared for CLR_HOLD cycles.
            state   <= OFF;
            cnt     <= CNT_CLR_HOLD;
            buf_clr <= 1'b1;
            buf_ce  <= 1'b0;
            gnt     <= '0;
            busy    <= 1'b0;
        end else begin
            case (state)
                OFF: begin
                    if (req_any && cnt == '0) begin
                        state   <= RELEASE;
                        cnt     <= CNT_RELEASE;
                        buf_clr <= 1'b0;
                        busy    <= 1'b1;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                end

                RELEASE: begin
                    if (cnt_done) begin
                        state  <= ENABLE;
                        cnt    <= CNT_SETTLE;
                        buf_ce <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                // Settle always runs to completion, even if requests vanish;
                // RUN then drains immediately if nobody is left.
                ENABLE: begin
                    if (cnt_done) begin
                        state <= RUN;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                RUN: begin
                    if (!req_any) begin
                        state  <= DRAIN;
                        cnt    <= CNT_DRAIN;
                        buf_ce <= 1'b0;
                        gnt    <= '0;
                    end else begin
                        gnt <= req;
                    end
                end

                // Two divided periods let the buffer output return low before
                // it is cleared.
                DRAIN: begin
                    if (cnt_done) begin
                        state   <= CLEAR;
                        cnt     <= CNT_CLR_HOLD;
                        buf_clr <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                CLEAR: begin
                    if (cnt_done) begin
                        state <= OFF;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                default: begin
                    state   <= OFF;
                    cnt     <= CNT_CLR_HOLD;
                    buf_clr <= 1'b1;
                    buf_ce  <= 1'b0;
                    gnt     <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

`ifdef CLKDIV_ENABLE_CTRL_PHASE_EN
    // Mod-DIVIDE phase of the divided clock. It restarts on ENABLE entry,
    // which is when the buffer starts counting, so phase 0 marks each rising
    // edge of the divided clock.
    localparam int               PHASE_W    = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(DIVIDE - 1);

    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] phase_inc;

    assign phase_inc = (phase == PHASE_LAST) ? '0 : phase + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase     <= '0;
            phase_stb <= 1'b0;
        end else begin
            case (state)
                RELEASE: begin
                    phase_stb <= 1'b0;
                    if (cnt_done) begin
                        phase <= '0;
                    end
                end
                ENABLE: begin
                    phase     <= phase_inc;
                    phase_stb <= cnt_done && (phase_inc == '0);
                end
                RUN: begin
                    phase     <= phase_inc;
                    phase_stb <= req_any && (phase_inc == '0);
                end
                default: begin
                    phase_stb <= 1'b0;
                end
            endcase
        end
    end
`else
    // Phase tracking is compiled out: no phase counter and no phase_stb port.
`endif

endmodule

// File: tb/tb_clkdiv_enable_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clkdiv_enable_ctrl
//
// Directed stimulus with hand-computed expectations. Each expectation names
// the cycle it applies to; the stimulus side schedules them into a
// cycle-ordered queue and an independent monitor compares them on the falling
// edge of that cycle. "Cycle n" below counts rising edges since the initial
// reset release (cycle 1 is the first edge after release).
// Defaults: DIVIDE=4, NUM_REQ=2, CLR_HOLD=4, SETTLE=8.
// -----------------------------------------------------------------------------
module tb_clkdiv_enable_ctrl;

    localparam int B = 2;   // absolute edges elapsed before reset release

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req   = 2'b00;
    logic [1:0] gnt;
    logic       buf_ce;
    logic       buf_clr;
    logic       busy;
`ifdef CLKDIV_ENABLE_CTRL_PHASE_EN
    logic       phase_stb;
`endif

    clkdiv_enable_ctrl #(
        .DIVIDE  (4),
        .NUM_REQ (2),
        .CLR_HOLD(4),
        .SETTLE  (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .gnt      (gnt),
        .buf_ce   (buf_ce),
        .buf_clr  (buf_clr),
        .busy     (busy)
`ifdef CLKDIV_ENABLE_CTRL_PHASE_EN
        ,
        .phase_stb(phase_stb)
`endif
    );

    always #5 clk = ~clk;

    int gcyc = 0;
    always @(posedge clk) gcyc <= gcyc + 1;

    typedef enum {S_GNT, S_CE, S_CLR, S_BUSY, S_STB} sig_e;

    typedef struct {
        int         cyc;
        sig_e       sig;
        logic [7:0] val;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Schedule an expectation for cycle s, keeping the queue cycle-ordered.
    task automatic expect_at(input int s, input sig_e sig, input logic [7:0] val,
                             input string name);
        exp_t e;
        int   idx;
        e.cyc  = B + s;
        e.sig  = sig;
        e.val  = val;
        e.name = name;
        idx    = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].cyc > e.cyc) begin
                idx = i;
                break;
            end
        end
        sb.insert(idx, e);
    endtask

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] sample(input sig_e sig);
        case (sig)
            S_GNT:  return {6'b0, gnt};
            S_CE:   return {7'b0, buf_ce};
            S_CLR:  return {7'b0, buf_clr};
            S_BUSY: return {7'b0, busy};
`ifdef CLKDIV_ENABLE_CTRL_PHASE_EN
            S_STB:  return {7'b0, phase_stb};
`endif
            default: return 8'hxx;
        endcase
    endfunction

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= gcyc) begin
            e = sb.pop_front();
            if (e.cyc < gcyc) begin
                n_checks++;
                n_errors++;
                $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)",
                         e.name, e.cyc - B, gcyc - B);
            end else begin
                check($sformatf("%s@%0d", e.name, e.cyc - B), sample(e.sig), e.val);
            end
        end
    end

    // Move to just after the rising edge that starts cycle s.
    task automatic at_cycle(input int s);
        while (gcyc < B + s) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: run still active at %0t, limit 100000", $time);
        $fatal(1);
    end

    initial begin : stimulus
        // Reset values, sampled while rst_n is still low.
        expect_at(-1, S_CLR,  8'd1, "rst_clr");
        expect_at(-1, S_CE,   8'd0, "rst_ce");
        expect_at(-1, S_GNT,  8'd0, "rst_gnt");
        expect_at(-1, S_BUSY, 8'd0, "rst_busy");
        at_cycle(0);
        rst_n = 1'b1;

        // Startup: clear-hold elapses, then req=01 in cycle 10.
        at_cycle(10);
        req = 2'b01;
        expect_at(10, S_CLR,  8'd1, "idle_clr");
        expect_at(10, S_BUSY, 8'd0, "idle_busy");
        expect_at(11, S_CLR,  8'd0, "rel_clr");
        expect_at(11, S_BUSY, 8'd1, "rel_busy");
        expect_at(12, S_CE,   8'd0, "rel_ce");
        expect_at(13, S_CE,   8'd1, "en_ce");
        expect_at(21, S_GNT,  8'd0, "settle_gnt");
        expect_at(21, S_CE,   8'd1, "run_ce");
        expect_at(22, S_GNT,  8'd1, "first_gnt");
`ifdef CLKDIV_ENABLE_CTRL_PHASE_EN
        expect_at(20, S_STB,  8'd0, "stb_settle");
        expect_at(21, S_STB,  8'd1, "stb_first");
        expect_at(22, S_STB,  8'd0, "stb_off");
        expect_at(24, S_STB,  8'd0, "stb_off2");
        expect_at(25, S_STB,  8'd1, "stb_second");
        expect_at(29, S_STB,  8'd1, "stb_third");
`endif

        // Requesters join and leave independently.
        at_cycle(25);
        req = 2'b11;
        expect_at(25, S_GNT, 8'd1, "join_before");
        expect_at(26, S_GNT, 8'd3, "join_gnt");
        at_cycle(30);
        req = 2'b10;
        expect_at(30, S_GNT, 8'd3, "leave_before");
        expect_at(31, S_GNT, 8'd2, "leave_gnt");
        expect_at(31, S_CE,  8'd1, "leave_ce");

        // All requests drop: drain, clear, off.
        at_cycle(35);
        req = 2'b00;
        expect_at(36, S_CE,   8'd0, "drain_ce");
        expect_at(36, S_GNT,  8'd0, "drain_gnt");
        expect_at(36, S_BUSY, 8'd1, "drain_busy");
        expect_at(43, S_CLR,  8'd0, "drain_end_clr");
        expect_at(44, S_CLR,  8'd1, "clear_clr");
        expect_at(47, S_BUSY, 8'd1, "clear_busy");
        expect_at(48, S_BUSY, 8'd0, "off_busy");
        expect_at(48, S_CLR,  8'd1, "off_clr");

        // Restart, then drop and re-request during DRAIN.
        at_cycle(50);
        req = 2'b01;
        expect_at(62, S_GNT, 8'd1, "restart_gnt");
        at_cycle(65);
        req = 2'b00;
        expect_at(66, S_CE,  8'd0, "drain2_ce");
        at_cycle(68);
        req = 2'b01;
        expect_at(70, S_GNT,  8'd0, "hold_drain_gnt");
        expect_at(74, S_CLR,  8'd1, "hold_clear_clr");
        expect_at(75, S_GNT,  8'd0, "hold_clear_gnt");
        expect_at(77, S_BUSY, 8'd1, "hold_clear_busy");
        expect_at(78, S_BUSY, 8'd0, "hold_off_busy");
        expect_at(78, S_GNT,  8'd0, "hold_off_gnt");
        expect_at(79, S_CLR,  8'd0, "rerel_clr");
        expect_at(81, S_CE,   8'd1, "reen_ce");
        expect_at(89, S_GNT,  8'd0, "resettle_gnt");
        expect_at(90, S_GNT,  8'd1, "rerun_gnt");

        // Asynchronous reset mid-RUN with req held.
        expect_at(94, S_GNT, 8'd1, "prerst_gnt");
        at_cycle(95);
        rst_n = 1'b0;
        expect_at(95, S_CE,   8'd0, "arst_ce");
        expect_at(95, S_CLR,  8'd1, "arst_clr");
        expect_at(95, S_GNT,  8'd0, "arst_gnt");
        expect_at(95, S_BUSY, 8'd0, "arst_busy");
        at_cycle(97);
        rst_n = 1'b1;
        expect_at(101, S_CLR,  8'd1, "rhold_clr");
        expect_at(101, S_BUSY, 8'd0, "rhold_busy");
        expect_at(102, S_CLR,  8'd0, "rrel_clr");
        expect_at(102, S_BUSY, 8'd1, "rrel_busy");
        expect_at(103, S_CE,   8'd0, "rrel_ce");
        expect_at(104, S_CE,   8'd1, "ren_ce");
        expect_at(112, S_GNT,  8'd0, "rsettle_gnt");
        expect_at(113, S_GNT,  8'd1, "rrun_gnt");

        at_cycle(120);
        @(negedge clk);
        #1;
        while (sb.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: expectation for cycle %0d never reached", sb[0].name,
                     sb[0].cyc - B);
            void'(sb.pop_front());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
